// File: rtl/lcg_stream_checker.sv
// Receive-side checker for the 32-bit LCG stream x' = x*0x41C64E6D + 0x3039 (mod 2^32).
// Latency: flags and counters update on the edge that accepts a word; expected is combinational from track.
// Backpressure: none, one word per cycle is always accepted when in_valid is high and clear is low.
module lcg_stream_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             locked,
    output logic             err_pulse,
    output logic [31:0]      expected,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int RUN_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0] LOSS_RUN = RUN_W'(LOSS_COUNT);

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [31:0]      track;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_inc;
    logic [31:0]      next_word;
    logic             hit;

    // 32x32 product truncated to 32 bits is exactly the mod 2^32 step.
    assign next_word = track * 32'h41C6_4E6D + 32'h0000_3039;
    assign expected  = next_word;
    assign hit       = (in_data == next_word);
    assign run_inc   = run + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEEK;
            track       <= '0;
            run         <= '0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            match_count <= '0;
            err_count   <= '0;
        end else if (clear) begin
            state       <= SEEK;
            track       <= '0;
            run         <= '0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            match_count <= '0;
            err_count   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                case (state)
                    SEEK: begin
                        track <= in_data;
                        run   <= '0;
                        state <= SYNC;
                    end
                    SYNC: begin
                        track <= in_data;
                        if (!hit) begin
                            run <= '0;
                        end else if (run_inc == LOCK_RUN) begin
                            run    <= '0;
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            run <= run_inc;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            track <= in_data;
                            run   <= '0;
                            if (match_count != '1)
                                match_count <= match_count + 1'b1;
                        end else begin
                            // Reference free-runs so a corrupted word cannot steer the sequence.
                            track     <= next_word;
                            err_pulse <= 1'b1;
                            if (err_count != '1)
                                err_count <= err_count + 1'b1;
                            if (run_inc == LOSS_RUN) begin
                                run    <= '0;
                                state  <= SEEK;
                                locked <= 1'b0;
                            end else begin
                                run <= run_inc;
                            end
                        end
                    end
                    default: begin
                        state  <= SEEK;
                        run    <= '0;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcg_stream_checker.sv
// Directed bench for lcg_stream_checker: lock, errors, loss, resync, gaps, reset, clear, saturation.
module tb_lcg_stream_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        locked, err_pulse;
    logic [31:0] expected;
    logic [15:0] match_count, err_count;

    logic        s_clear = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_locked, s_err_pulse;
    logic [31:0] s_expected;
    logic [3:0]  s_match_count, s_err_count;

    int tests = 0;
    int fails = 0;
    logic [31:0] w;

    always #5 clk = ~clk;

    lcg_stream_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .locked(locked), .err_pulse(err_pulse), .expected(expected),
        .match_count(match_count), .err_count(err_count)
    );

    lcg_stream_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .clear(s_clear), .in_valid(s_valid), .in_data(s_data),
        .locked(s_locked), .err_pulse(s_err_pulse), .expected(s_expected),
        .match_count(s_match_count), .err_count(s_err_count)
    );

    function automatic logic [31:0] lcg(input logic [31:0] x);
        logic [63:0] p;
        p = {32'd0, x} * 64'h0000_0000_41C6_4E6D + 64'h3039;
        return p[31:0];
    endfunction

    // Drive one cycle, let the edge happen, then leave outputs settled for checking.
    task automatic put(input logic v, input logic [31:0] d, input logic c);
        in_valid = v;
        in_data  = d;
        clear    = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic s_put(input logic v, input logic [31:0] d);
        s_valid = v;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked got %0b want 0", locked); end
        tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL reset_err_pulse got %0b want 0", err_pulse); end
        tests++; if (match_count !== 16'd0 || err_count !== 16'd0) begin fails++; $display("FAIL reset_counts got %0d/%0d want 0/0", match_count, err_count); end
        tests++; if (expected !== 32'h0000_3039) begin fails++; $display("FAIL reset_expected got %h want 00003039", expected); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lock;
        put(1'b1, 32'h0000_0000, 1'b0);
        tests++; if (expected !== 32'h0000_3039) begin fails++; $display("FAIL lock_expected0 got %h want 00003039", expected); end
        put(1'b1, 32'h0000_3039, 1'b0);
        tests++; if (expected !== 32'hD3DC_167E) begin fails++; $display("FAIL lock_expected1 got %h want d3dc167e", expected); end
        put(1'b1, 32'hD3DC_167E, 1'b0);
        w = 32'hD3DC_167E;
        w = lcg(w); put(1'b1, w, 1'b0);
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL lock_early got %0b want 0", locked); end
        w = lcg(w); put(1'b1, w, 1'b0);
        tests++; if (locked !== 1'b1 || match_count !== 16'd0) begin fails++; $display("FAIL lock_5th got locked=%0b mc=%0d want 1/0", locked, match_count); end
        w = lcg(w); put(1'b1, w, 1'b0);
        tests++; if (match_count !== 16'd1) begin fails++; $display("FAIL lock_mc1 got %0d want 1", match_count); end
        w = lcg(w); put(1'b1, w, 1'b0);
        tests++; if (match_count !== 16'd2) begin fails++; $display("FAIL lock_mc2 got %0d want 2", match_count); end
    endtask

    task automatic test_single_error;
        w = lcg(w); put(1'b1, w ^ 32'h1, 1'b0);
        tests++; if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin fails++; $display("FAIL single_err got pulse=%0b ec=%0d locked=%0b want 1/1/1", err_pulse, err_count, locked); end
        w = lcg(w); put(1'b1, w, 1'b0);
        tests++; if (err_pulse !== 1'b0 || match_count !== 16'd3) begin fails++; $display("FAIL single_err_resume got pulse=%0b mc=%0d want 0/3", err_pulse, match_count); end
    endtask

    task automatic test_loss;
        logic [31:0] garbage [3];
        garbage[0] = 32'h0000_0000;
        garbage[1] = 32'hFFFF_FFFF;
        garbage[2] = 32'h5A5A_5A5A;
        for (int i = 0; i < 3; i++) begin
            w = lcg(w);
            put(1'b1, garbage[i], 1'b0);
            tests++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL loss_pulse%0d got %0b want 1", i, err_pulse); end
            tests++; if (locked !== (i < 2)) begin fails++; $display("FAIL loss_locked%0d got %0b want %0b", i, locked, (i < 2)); end
        end
        tests++; if (err_count !== 16'd4) begin fails++; $display("FAIL loss_ec got %0d want 4", err_count); end
        for (int i = 0; i < 5; i++) begin
            w = lcg(w);
            put(1'b1, w, 1'b0);
            tests++; if (locked !== (i == 4)) begin fails++; $display("FAIL relock%0d got %0b want %0b", i, locked, (i == 4)); end
        end
        tests++; if (match_count !== 16'd3 || err_pulse !== 1'b0) begin fails++; $display("FAIL relock_mc got mc=%0d pulse=%0b want 3/0", match_count, err_pulse); end
    endtask

    task automatic test_sync_resync;
        put(1'b0, 32'h0, 1'b1);
        tests++; if (match_count !== 16'd0 || err_count !== 16'd0 || locked !== 1'b0) begin fails++; $display("FAIL clear_counts got %0d/%0d locked=%0b want 0/0/0", match_count, err_count, locked); end
        w = 32'h1234_5678; put(1'b1, w, 1'b0);
        w = lcg(w); put(1'b1, w, 1'b0);
        w = lcg(w); put(1'b1, w, 1'b0);
        w = 32'hCAFE_F00D; put(1'b1, w, 1'b0);
        for (int i = 0; i < 4; i++) begin
            w = lcg(w);
            put(1'b1, w, 1'b0);
            tests++; if (locked !== (i == 3)) begin fails++; $display("FAIL resync%0d got %0b want %0b", i, locked, (i == 3)); end
        end
        tests++; if (match_count !== 16'd0 || err_count !== 16'd0) begin fails++; $display("FAIL resync_counts got %0d/%0d want 0/0", match_count, err_count); end
    endtask

    task automatic test_gap;
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            put(1'b0, 32'hFFFF_0000 ^ i, 1'b0);
            if (err_pulse !== 1'b0 || locked !== 1'b1) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL gap_hold got %0d bad cycles want 0", bad); end
        w = lcg(w); put(1'b1, w, 1'b0);
        tests++; if (match_count !== 16'd1 || err_count !== 16'd0) begin fails++; $display("FAIL gap_resume got %0d/%0d want 1/0", match_count, err_count); end
    endtask

    task automatic test_async_reset;
        rst = 1'b1;
        #1;
        tests++; if (locked !== 1'b0 || match_count !== 16'd0 || expected !== 32'h0000_3039) begin fails++; $display("FAIL async_rst got locked=%0b mc=%0d exp=%h want 0/0/00003039", locked, match_count, expected); end
        rst = 1'b0;
        w = 32'h0BAD_BEEF;
        put(1'b1, w, 1'b0);
        for (int i = 0; i < 4; i++) begin
            w = lcg(w);
            put(1'b1, w, 1'b0);
        end
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL async_relock got %0b want 1", locked); end
        w = lcg(w); put(1'b1, w, 1'b0);
    endtask

    task automatic test_clear;
        w = lcg(w);
        put(1'b1, w, 1'b1);
        tests++; if (locked !== 1'b0 || match_count !== 16'd0 || err_count !== 16'd0) begin fails++; $display("FAIL clear_locked got locked=%0b mc=%0d ec=%0d want 0/0/0", locked, match_count, err_count); end
        tests++; if (expected !== 32'h0000_3039) begin fails++; $display("FAIL clear_word_ignored got %h want 00003039", expected); end
    endtask

    task automatic test_saturation;
        w = 32'h0000_0001;
        s_put(1'b1, w);
        for (int i = 0; i < 4; i++) begin
            w = lcg(w);
            s_put(1'b1, w);
        end
        tests++; if (s_locked !== 1'b1 || s_match_count !== 4'd0) begin fails++; $display("FAIL sat_lock got locked=%0b mc=%0d want 1/0", s_locked, s_match_count); end
        for (int i = 0; i < 20; i++) begin
            w = lcg(w);
            s_put(1'b1, w);
        end
        tests++; if (s_match_count !== 4'd15) begin fails++; $display("FAIL sat_mc got %0d want 15", s_match_count); end
        w = lcg(w); s_put(1'b1, ~w);
        tests++; if (s_err_pulse !== 1'b1 || s_err_count !== 4'd1 || s_match_count !== 4'd15) begin fails++; $display("FAIL sat_err got pulse=%0b ec=%0d mc=%0d want 1/1/15", s_err_pulse, s_err_count, s_match_count); end
    endtask

    initial begin
        test_reset;
        test_lock;
        test_single_error;
        test_loss;
        test_sync_resync;
        test_gap;
        test_async_reset;
        test_clear;
        test_saturation;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
